cpu: RTL and testbench
======================

// Module: cpu
// PURPOSE
// - Minimal 16-bit multi-cycle von Neumann CPU: 4 GPRs, one unified instruction/data RAM, ALU (ADD/SUB/MUL/DIV), LOAD/STORE.
// - Top-level block with only clock and reset ports.
// - Software state is observed hierarchically through the register file and RAM instances.
// PARAMETERS
// - DATA_WIDTH  16   register, ALU and RAM word width.
// - ADDR_WIDTH  16   PC and effective-address width.
// - MEM_DEPTH   256  RAM words. Index = address modulo MEM_DEPTH.
// PORTS
// - clk  input  1  single clock. All state updates on the rising edge.
// - rst  input  1  synchronous, active-high reset.
// BEHAVIOUR
// Required hierarchy (benches probe it):
// - Instance `ram` holds array `mem[0:MEM_DEPTH-1]` of DATA_WIDTH bits.
// - Instance `RF` holds registers `x0`..`x3`, each with a `q` output.
// Reset (rst=1 at posedge):
// - PC=0, IR=0, x0..x3=0, FSM=FETCH.
// - RAM is NOT cleared; it may be preloaded while rst is high.
// - Reset asserted mid-instruction aborts that instruction with no register or RAM write.
// Instruction format:
// - [15:13] op, [12:11] rd, [10:9] rs1, [8:7] rs2 (R-type), [8:0] imm9 (memory type, zero-extended).
// Opcodes:
// - 000 ADD: rd <= rs1 + rs2.
// - 001 SUB: rd <= rs1 - rs2.
// - 010 MUL: rd <= low DATA_WIDTH bits of rs1 * rs2.
// - 011 DIV: rd <= unsigned rs1 / rs2. Divide by zero gives all-ones.
// - 100 LOAD: rd <= mem[rs1 + imm9].
// - 101 STORE: mem[rs1 + imm9] <= rd (rd field is the data source).
// - 110, 111: no operation.
// - Instruction word 16'h0000 is a NOP, not ADD x0,x0,x0. Zero-filled RAM executes as NOPs.
// Arithmetic: unsigned; results and addresses wrap modulo 2^width, no flags.
// FSM, 4 cycles per instruction, no stalls:
// - FETCH: IR <= mem[PC]; PC <= PC+1 (wraps).
// - DECODE: latch A <= R[rs1], B <= R[rs2]; latch rd value for STORE.
// - EXECUTE: ALU result or effective address <= A + imm9.
// - WRITEBACK: ALU ops and LOAD write rd; STORE writes RAM; NOP writes nothing. Then back to FETCH.
// RAM timing: asynchronous read, synchronous write; one write per cycle at most.
// Data hazards: none; each instruction completes before the next fetch.
// Self-modifying code: a STORE into a later instruction slot takes effect on that instruction's fetch.
// TESTING
// Initial image:
// - RAM cleared; mem[100]=5, mem[101]=7.
// - Program at mem[3..12]: LOAD x1,[x0+100]; LOAD x2,[x0+101]; MUL x3,x1,x2; SUB x0,x2,x1;
//   STORE x3,[x3+100]; LOAD x1,[x3+100]; SUB x2,x1,x0; 16'h0000; ADD x3,x2,x0; DIV x2,x3,x0.
// - Hold rst 2 cycles, then run 150 cycles.
// Directed scenarios:
// 1. Full program -> x0=2, x1=35, x2=17, x3=35; mem[100]=5, mem[101]=7, mem[135]=35.
// 2. Reset preload: mem written during rst, rst high 2 cycles -> mem contents retained; PC=0; all x=0; first fetch from address 0.
// 3. NOP: 16'h0000 executed with x0=2 -> x0 stays 2 (not 4); PC advances by 1.
// 4. Arithmetic edges:
//    - 0xFFFF + 1 -> 0.
//    - 3 - 5 -> 0xFFFE.
//    - 0x0100 * 0x0100 -> 0.
//    - 35 / 2 -> 17.
//    - 7 / 0 -> 0xFFFF.
// 5. STORE then LOAD same address: x3=35, STORE [x3+100] then LOAD x1,[x3+100] -> mem[135]=35, x1=35; no other RAM word changes.
// 6. Mid-instruction reset: rst during EXECUTE of a STORE -> no RAM write; registers cleared; restart at PC=0.

Source files
------------

// File: rtl/cpu_if.sv
// Unified memory bus between the CPU core and its single-port RAM.
// One address serves both instruction fetch and data access.
interface cpu_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/cpu.sv
// Minimal 16-bit multi-cycle von Neumann CPU: 4 GPRs, unified RAM, ALU and LOAD/STORE.
// Every instruction runs FETCH -> DECODE -> EXECUTE -> WRITEBACK with no stalls.
module cpu_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 256
) (
  input logic   clk,
  cpu_if.slave  bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];
  logic [IDX_W-1:0]      idx_s;

  assign idx_s     = IDX_W'(bus.addr % ADDR_WIDTH'(MEM_DEPTH));
  assign bus.rdata = mem[idx_s];

  // Synchronous write port; contents survive reset so images can be preloaded.
  always_ff @(posedge clk) begin
    if (bus.we) begin
      mem[idx_s] <= bus.wdata;
    end
  end
endmodule

module cpu_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  // Next-value select for a single architectural register.
  always_comb begin
    val_d = val_q;
    if (we) begin
      val_d = d;
    end else begin
      val_d = val_q;
    end
  end

  // Register storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= {W{1'b0}};
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;
endmodule

module cpu_regfile #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [1:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [1:0]   raddr_a,
  input  logic [1:0]   raddr_b,
  input  logic [1:0]   raddr_c,
  output logic [W-1:0] rdata_a,
  output logic [W-1:0] rdata_b,
  output logic [W-1:0] rdata_c
);
  logic [W-1:0] r0_s, r1_s, r2_s, r3_s;

  function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] c,
                                        input logic [W-1:0] d);
    case (sel)
      2'd0:    pick = a;
      2'd1:    pick = b;
      2'd2:    pick = c;
      2'd3:    pick = d;
      default: pick = a;
    endcase
  endfunction

  cpu_reg #(.W(W)) x0 (.clk(clk), .rst(rst), .we(we && (waddr == 2'd0)), .d(wdata), .q(r0_s));
  cpu_reg #(.W(W)) x1 (.clk(clk), .rst(rst), .we(we && (waddr == 2'd1)), .d(wdata), .q(r1_s));
  cpu_reg #(.W(W)) x2 (.clk(clk), .rst(rst), .we(we && (waddr == 2'd2)), .d(wdata), .q(r2_s));
  cpu_reg #(.W(W)) x3 (.clk(clk), .rst(rst), .we(we && (waddr == 2'd3)), .d(wdata), .q(r3_s));

  assign rdata_a = pick(raddr_a, r0_s, r1_s, r2_s, r3_s);
  assign rdata_b = pick(raddr_b, r0_s, r1_s, r2_s, r3_s);
  assign rdata_c = pick(raddr_c, r0_s, r1_s, r2_s, r3_s);
endmodule

module cpu #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 256
) (
  input logic clk,
  input logic rst
);
  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, sd_q, sd_d, res_q, res_d;

  logic [2:0]            op_s;
  logic [1:0]            rd_s, rs1_s, rs2_s;
  logic [DATA_WIDTH-1:0] imm_s;
  logic                  is_nop_s;
  logic [DATA_WIDTH-1:0] rf_a_s, rf_b_s, rf_c_s, rf_wdata_s;
  logic                  rf_we_s, mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;

  cpu_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) mem_bus ();

  cpu_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH)) ram (
    .clk(clk), .bus(mem_bus)
  );

  cpu_regfile #(.W(DATA_WIDTH)) RF (
    .clk(clk), .rst(rst), .we(rf_we_s && !rst), .waddr(rd_s), .wdata(rf_wdata_s),
    .raddr_a(rs1_s), .raddr_b(rs2_s), .raddr_c(rd_s),
    .rdata_a(rf_a_s), .rdata_b(rf_b_s), .rdata_c(rf_c_s)
  );

  assign op_s     = ir_q[15:13];
  assign rd_s     = ir_q[12:11];
  assign rs1_s    = ir_q[10:9];
  assign rs2_s    = ir_q[8:7];
  assign imm_s    = {{(DATA_WIDTH-9){1'b0}}, ir_q[8:0]};
  // The all-zero word must not execute as ADD x0,x0,x0 so blank RAM is inert.
  assign is_nop_s = (ir_q == {DATA_WIDTH{1'b0}}) || (op_s[2:1] == 2'b11);

  // A reset landing mid-instruction must not let a pending RAM write through.
  assign mem_bus.addr  = mem_addr_s;
  assign mem_bus.wdata = sd_q;
  assign mem_bus.we    = mem_we_s && !rst;

  // Sequencer: next state, datapath latches and writeback strobes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    sd_d       = sd_q;
    res_d      = res_q;
    rf_we_s    = 1'b0;
    rf_wdata_s = res_q;
    mem_we_s   = 1'b0;
    mem_addr_s = pc_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = mem_bus.rdata;
        pc_d    = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rf_a_s;
        b_d     = rf_b_s;
        sd_d    = rf_c_s;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (op_s)
          OP_ADD:  res_d = a_q + b_q;
          OP_SUB:  res_d = a_q - b_q;
          OP_MUL:  res_d = a_q * b_q;
          OP_DIV: begin
            if (b_q == {DATA_WIDTH{1'b0}}) begin
              res_d = {DATA_WIDTH{1'b1}};
            end else begin
              res_d = a_q / b_q;
            end
          end
          default: res_d = a_q + imm_s;
        endcase
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        mem_addr_s = ADDR_WIDTH'(res_q);
        if (is_nop_s) begin
          rf_we_s = 1'b0;
        end else begin
          case (op_s)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: rf_we_s = 1'b1;
            OP_LOAD: begin
              rf_we_s    = 1'b1;
              rf_wdata_s = mem_bus.rdata;
            end
            OP_STORE: mem_we_s = 1'b1;
            default:  rf_we_s  = 1'b0;
          endcase
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= {ADDR_WIDTH{1'b0}};
      ir_q    <= {DATA_WIDTH{1'b0}};
      a_q     <= {DATA_WIDTH{1'b0}};
      b_q     <= {DATA_WIDTH{1'b0}};
      sd_q    <= {DATA_WIDTH{1'b0}};
      res_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sd_q    <= sd_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: small programs are preloaded during reset and the
// architectural state is compared against queued expectations after a fixed run.
module tb_cpu;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    int          kind;   // 0 reg, 1 mem, 2 pc, 3 ir, 4 state
    int          idx;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb[$];
  string       sb_name[$];
  logic [15:0] img [0:255];

  cpu dut (.clk(clk), .rst(rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] observe(input int kind, input int idx);
    logic [15:0] v;
    v = 16'h0000;
    case (kind)
      0: begin
        case (idx)
          0: v = dut.RF.x0.q;
          1: v = dut.RF.x1.q;
          2: v = dut.RF.x2.q;
          default: v = dut.RF.x3.q;
        endcase
      end
      1: v = dut.ram.mem[idx];
      2: v = dut.pc_q;
      3: v = dut.ir_q;
      default: v = 16'(dut.state_q);
    endcase
    return v;
  endfunction

  task automatic expect_val(input string name, input int kind, input int idx, input logic [15:0] v);
    exp_t e;
    e.kind = kind; e.idx = idx; e.exp = v;
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  task automatic poke(input int a, input logic [15:0] v);
    img[a] = v;
    dut.ram.mem[a] = v;
  endtask

  task automatic begin_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) poke(i, 16'h0000);
  endtask

  task automatic end_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_full_program();
    exp_t e; string nm; logic [15:0] got; int changed;
    begin_reset();
    poke(100, 16'd5); poke(101, 16'd7);
    poke(3, 16'h8864); poke(4, 16'h9065); poke(5, 16'h5B00); poke(6, 16'h2480);
    poke(7, 16'hBE64); poke(8, 16'h8E64); poke(9, 16'h3200); poke(10, 16'h0000);
    poke(11, 16'h1C00); poke(12, 16'h7600);
    end_reset();
    expect_val("prog_x0", 0, 0, 16'd2);
    expect_val("prog_x1", 0, 1, 16'd35);
    expect_val("prog_x2", 0, 2, 16'd17);
    expect_val("prog_x3", 0, 3, 16'd35);
    expect_val("prog_m100", 1, 100, 16'd5);
    expect_val("prog_m101", 1, 101, 16'd7);
    expect_val("prog_m135", 1, 135, 16'd35);
    step(150);
    while (sb.size() > 0) begin
      e = sb.pop_front(); nm = sb_name.pop_front(); got = observe(e.kind, e.idx);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, got, e.exp);
      end
    end
    changed = 0;
    for (int i = 0; i < 256; i++) if (i != 135 && dut.ram.mem[i] !== img[i]) changed++;
    checks++;
    if (changed !== 0) begin
      errors++;
      $display("FAIL prog_other_ram: got %0d changed words expected 0", changed);
    end
  endtask

  task automatic test_reset();
    exp_t e; string nm; logic [15:0] got;
    begin_reset();
    poke(0, 16'h80C8); poke(77, 16'hBEEF); poke(200, 16'h1234);
    end_reset();
    for (int r = 0; r < 4; r++) expect_val($sformatf("rst_x%0d", r), 0, r, 16'h0000);
    expect_val("rst_pc", 2, 0, 16'h0000);
    expect_val("rst_ir", 3, 0, 16'h0000);
    expect_val("rst_state", 4, 0, 16'h0000);
    expect_val("rst_m77_kept", 1, 77, 16'hBEEF);
    expect_val("rst_m200_kept", 1, 200, 16'h1234);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); nm = sb_name.pop_front(); got = observe(e.kind, e.idx);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, got, e.exp);
      end
    end
    expect_val("rst_first_ir", 3, 0, 16'h80C8);
    expect_val("rst_first_pc", 2, 0, 16'h0001);
    step(1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); nm = sb_name.pop_front(); got = observe(e.kind, e.idx);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, got, e.exp);
      end
    end
  endtask

  task automatic test_nop();
    exp_t e; string nm; logic [15:0] got;
    begin_reset();
    poke(0, 16'h80C8); poke(1, 16'h0000); poke(200, 16'd2);
    end_reset();
    for (int ph = 1; ph <= 2; ph++) begin
      expect_val($sformatf("nop_x0_%0d", ph), 0, 0, 16'd2);
      expect_val($sformatf("nop_pc_%0d", ph), 2, 0, 16'(ph));
      step(4);
      while (sb.size() > 0) begin
        e = sb.pop_front(); nm = sb_name.pop_front(); got = observe(e.kind, e.idx);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_arith();
    exp_t e; string nm; logic [15:0] got;
    logic [15:0] av [5]; logic [15:0] bv [5]; logic [15:0] ow [5]; logic [15:0] rv [5];
    string names [5];
    av = '{16'hFFFF, 16'd3, 16'h0100, 16'd35, 16'd7};
    bv = '{16'h0001, 16'd5, 16'h0100, 16'd2, 16'd0};
    ow = '{16'h1B00, 16'h3B00, 16'h5B00, 16'h7B00, 16'h7B00};
    rv = '{16'h0000, 16'hFFFE, 16'h0000, 16'd17, 16'hFFFF};
    names = '{"add_wrap", "sub_wrap", "mul_wrap", "div_35_2", "div_by_zero"};
    for (int k = 0; k < 5; k++) begin
      begin_reset();
      poke(200, av[k]); poke(201, bv[k]);
      poke(0, 16'h88C8); poke(1, 16'h90C9); poke(2, ow[k]);
      end_reset();
      expect_val(names[k], 0, 3, rv[k]);
      expect_val({names[k], "_x0"}, 0, 0, 16'h0000);
      step(16);
      while (sb.size() > 0) begin
        e = sb.pop_front(); nm = sb_name.pop_front(); got = observe(e.kind, e.idx);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_store_load();
    exp_t e; string nm; logic [15:0] got; int changed;
    begin_reset();
    poke(200, 16'd35); poke(0, 16'h98C8); poke(1, 16'hBE64); poke(2, 16'h8E64);
    end_reset();
    expect_val("sl_m135", 1, 135, 16'd35);
    expect_val("sl_x1", 0, 1, 16'd35);
    expect_val("sl_x3", 0, 3, 16'd35);
    step(12);
    while (sb.size() > 0) begin
      e = sb.pop_front(); nm = sb_name.pop_front(); got = observe(e.kind, e.idx);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, got, e.exp);
      end
    end
    changed = 0;
    for (int i = 0; i < 256; i++) if (i != 135 && dut.ram.mem[i] !== img[i]) changed++;
    checks++;
    if (changed !== 0) begin
      errors++;
      $display("FAIL sl_other_ram: got %0d changed words expected 0", changed);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e; string nm; logic [15:0] got;
    begin_reset();
    poke(200, 16'd35); poke(0, 16'h98C8); poke(1, 16'hB832);
    end_reset();
    step(6);
    expect_val("mid_in_execute", 4, 0, 16'd2);
    expect_val("mid_x3_loaded", 0, 3, 16'd35);
    while (sb.size() > 0) begin
      e = sb.pop_front(); nm = sb_name.pop_front(); got = observe(e.kind, e.idx);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, got, e.exp);
      end
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    expect_val("mid_no_store", 1, 50, 16'h0000);
    expect_val("mid_x3_cleared", 0, 3, 16'h0000);
    expect_val("mid_pc_zero", 2, 0, 16'h0000);
    expect_val("mid_state_fetch", 4, 0, 16'd0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); nm = sb_name.pop_front(); got = observe(e.kind, e.idx);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, got, e.exp);
      end
    end
    expect_val("mid_restart_x3", 0, 3, 16'd35);
    expect_val("mid_restart_pc", 2, 0, 16'd1);
    step(4);
    while (sb.size() > 0) begin
      e = sb.pop_front(); nm = sb_name.pop_front(); got = observe(e.kind, e.idx);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, got, e.exp);
      end
    end
    expect_val("mid_store_after", 1, 50, 16'd35);
    step(4);
    while (sb.size() > 0) begin
      e = sb.pop_front(); nm = sb_name.pop_front(); got = observe(e.kind, e.idx);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, got, e.exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_full_program();
    test_reset();
    test_nop();
    test_arith();
    test_store_load();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
